// File: rtl/lab_disp_pkg.sv
// Shared display definitions for the lab counter boards: glyph type and
// active-high 7-segment encodings {g,f,e,d,c,b,a} for hex digits 0-F.
package lab_disp_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0 = 7'b0111111;
    localparam seg7_t SEG_1 = 7'b0000110;
    localparam seg7_t SEG_2 = 7'b1011011;
    localparam seg7_t SEG_3 = 7'b1001111;
    localparam seg7_t SEG_4 = 7'b1100110;
    localparam seg7_t SEG_5 = 7'b1101101;
    localparam seg7_t SEG_6 = 7'b1111101;
    localparam seg7_t SEG_7 = 7'b0000111;
    localparam seg7_t SEG_8 = 7'b1111111;
    localparam seg7_t SEG_9 = 7'b1101111;
    localparam seg7_t SEG_A = 7'b1110111;
    localparam seg7_t SEG_B = 7'b1111100;
    localparam seg7_t SEG_C = 7'b0111001;
    localparam seg7_t SEG_D = 7'b1011110;
    localparam seg7_t SEG_E = 7'b1111001;
    localparam seg7_t SEG_F = 7'b1110001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder, active-high output {g,f,e,d,c,b,a}.
// Polarity is left to the caller so other labs can reuse it unchanged.
module seg7_decode
    import lab_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_0;
        case (digit_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, per-frame value
// snapshot, leading-zero blanking and one dark cycle per slot against ghosting.
module seg7_scan_driver
    import lab_disp_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int   PREW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic INV  = (ACTIVE_LOW != 0);

    logic [PREW-1:0]     pre_q, pre_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic                lzSnap_q, lzSnap_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [3:0]          curDigit;
    logic                curDp;
    logic                curZeroUpper;
    logic [DIGITS-1:0]   anSel;
    logic [DIGITS-1:0]   zeroUpper;
    logic                running;
    logic                curBlank;
    seg7_t               glyph;
    seg7_t               segHigh;
    logic                dpHigh;
    logic [DIGITS-1:0]   anHigh;

    // The snapshot is taken only on the last cycle of the last slot, so a frame never mixes two values.
    always_comb begin
        pre_d    = pre_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        lzSnap_d = lzSnap_q;
        if (en) begin
            if (pre_q == PREW'(DIV - 1)) begin
                pre_d = '0;
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    idx_d    = '0;
                    snap_d   = value;
                    lzSnap_d = blank_lz;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // zeroUpper[i] is set when snapshot digits i..DIGITS-1 are all zero.
    always_comb begin
        running      = 1'b1;
        zeroUpper    = '0;
        curDigit     = '0;
        curDp        = 1'b0;
        curZeroUpper = 1'b0;
        anSel        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            running      = running & (snap_q[4*i +: 4] == 4'd0);
            zeroUpper[i] = running;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                curDigit     = snap_q[4*i +: 4];
                curDp        = dp_mask[i];
                curZeroUpper = zeroUpper[i];
                anSel[i]     = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .digit_i (curDigit),
        .seg_o   (glyph)
    );

    assign curBlank = lzSnap_q && (idx_q != '0) && curZeroUpper;

    // Slot cycle pre==0 keeps everything dark so the previous digit cannot ghost.
    always_comb begin
        segHigh = '0;
        dpHigh  = 1'b0;
        anHigh  = '0;
        if (en && (pre_q != '0)) begin
            segHigh = curBlank ? 7'b0000000 : glyph;
            dpHigh  = curDp;
            anHigh  = anSel;
        end
        seg_d = segHigh ^ {7{INV}};
        dp_d  = dpHigh ^ INV;
        an_d  = anHigh ^ {DIGITS{INV}};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q    <= '0;
            idx_q    <= '0;
            snap_q   <= '0;
            lzSnap_q <= 1'b0;
            seg_q    <= {7{INV}};
            dp_q     <= INV;
            an_q     <= {DIGITS{INV}};
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            lzSnap_q <= lzSnap_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a behavioural display model queues the expected outputs
// at each edge; both polarities of the driver are compared on the falling edge.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [6:0]  segLow, segHigh;
    logic        dpLow, dpHigh;
    logic [3:0]  anLow, anHigh;

    int checks   = 0;
    int failures = 0;

    int          mPre, mIdx;
    logic [15:0] mSnap;
    logic        mLz;
    logic [11:0] expQ[$];

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1)) dutLow (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .seg(segLow), .dp(dpLow), .an(anLow)
    );

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(0)) dutHigh (
        .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .seg(segHigh), .dp(dpHigh), .an(anHigh)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [6:0] glyphOf(input logic [3:0] d);
        logic [6:0] table16 [16];
        table16 = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        return table16[d];
    endfunction

    // Reference model: expected active-high {seg,dp,an} for the edge just taken.
    always @(posedge clk) begin
        logic [6:0] eSeg;
        logic       eDp;
        logic [3:0] eAn;
        logic       blank;
        eSeg = '0;
        eDp  = 1'b0;
        eAn  = '0;
        if (!rst) begin
            mPre  = 0;
            mIdx  = 0;
            mSnap = '0;
            mLz   = 1'b0;
        end else if (en) begin
            if (mPre != 0) begin
                blank = mLz && (mIdx != 0) && ((mSnap >> (4 * mIdx)) == 16'd0);
                eSeg  = blank ? 7'b0 : glyphOf(mSnap[4*mIdx +: 4]);
                eDp   = dp_mask[mIdx];
                eAn   = 4'b0001 << mIdx;
            end
            if (mPre == DIV - 1) begin
                mPre = 0;
                if (mIdx == DIGITS - 1) begin
                    mIdx  = 0;
                    mSnap = value;
                    mLz   = blank_lz;
                end else begin
                    mIdx = mIdx + 1;
                end
            end else begin
                mPre = mPre + 1;
            end
        end
        expQ.push_back({eSeg, eDp, eAn});
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("segLow",  {9'b0, segLow},  {9'b0, ~e[11:5]});
            checkOutput("dpLow",   {15'b0, dpLow},  {15'b0, ~e[4]});
            checkOutput("anLow",   {12'b0, anLow},  {12'b0, ~e[3:0]});
            checkOutput("segHigh", {9'b0, segHigh}, {9'b0, e[11:5]});
            checkOutput("dpHigh",  {15'b0, dpHigh}, {15'b0, e[4]});
            checkOutput("anHigh",  {12'b0, anHigh}, {12'b0, e[3:0]});
        end
    end

    task automatic applyStimulus(input logic [15:0] v, input logic lz, input logic [3:0] dm, input int cycles);
        value    = v;
        blank_lz = lz;
        dp_mask  = dm;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        bit found;
        rst = 1'b0; en = 1'b1; value = '0; dp_mask = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstSeg", {9'b0, segLow}, 16'h007F);
        checkOutput("rstAn",  {12'b0, anLow}, 16'h000F);
        checkOutput("rstDp",  {15'b0, dpLow}, 16'h0001);
        checkOutput("rstAnHigh", {12'b0, anHigh}, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("firstDark", {12'b0, anLow}, 16'h000F);
        @(negedge clk);
        checkOutput("firstSeg", {9'b0, segLow}, {9'b0, 7'b1000000});
        checkOutput("firstAn",  {12'b0, anLow}, {12'b0, 4'b1110});

        applyStimulus(16'h1234, 1'b0, 4'b0000, 36);
        applyStimulus(16'h5678, 1'b0, 4'b0000, 40);
        applyStimulus(16'h0070, 1'b1, 4'b0000, 40);
        applyStimulus(16'h0000, 1'b1, 4'b0000, 40);

        dp_mask = 4'b0100;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (mIdx == 2 && mPre == 2) found = 1'b1;
        end
        checkOutput("reachDigit2", {15'b0, found}, 16'h0001);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (24) @(negedge clk);

        applyStimulus(16'h000F, 1'b0, 4'b0001, 36);

        for (int k = 0; k < 80; k++) begin
            value    = 16'($urandom);
            dp_mask  = 4'($urandom);
            blank_lz = 1'($urandom);
            en       = ($urandom_range(0, 5) != 0);
            @(negedge clk);
        end
        en = 1'b1;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'h9ABC, 1'b0, 4'b1010, 40);

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
